// File: rtl/sigma_mem_arb_if.sv
// Bus bundle between the sigma masters, the arbiter and the shared sigma slave port.
// The arbiter connects through the slave modport; the surrounding system uses master.
interface sigma_mem_arb_if #(
  parameter int NUM_M = 3,
  parameter int AW    = 32,
  parameter int DW    = 32
);
  logic [NUM_M-1:0]        m_req_i;
  logic [NUM_M-1:0]        m_we_i;
  logic [NUM_M*AW-1:0]     m_addr_i;
  logic [NUM_M*DW/8-1:0]   m_be_i;
  logic [NUM_M*DW-1:0]     m_wdata_i;
  logic [NUM_M-1:0]        m_ack_o;
  logic [NUM_M-1:0]        m_resp_o;
  logic [DW-1:0]           m_rdata_o;
  logic                    s_req_o;
  logic                    s_we_o;
  logic [AW-1:0]           s_addr_o;
  logic [DW/8-1:0]         s_be_o;
  logic [DW-1:0]           s_wdata_o;
  logic                    s_ack_i;
  logic                    s_resp_i;
  logic [DW-1:0]           s_rdata_i;

  modport slave (
    input  m_req_i, m_we_i, m_addr_i, m_be_i, m_wdata_i, s_ack_i, s_resp_i, s_rdata_i,
    output m_ack_o, m_resp_o, m_rdata_o, s_req_o, s_we_o, s_addr_o, s_be_o, s_wdata_o
  );

  modport master (
    output m_req_i, m_we_i, m_addr_i, m_be_i, m_wdata_i, s_ack_i, s_resp_i, s_rdata_i,
    input  m_ack_o, m_resp_o, m_rdata_o, s_req_o, s_we_o, s_addr_o, s_be_o, s_wdata_o
  );
endinterface

// File: rtl/sigma_mem_arb.sv
// Round-robin N-master arbiter for one sigma slave port, with an in-order read ID FIFO.
// Define SIGMA_MEM_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins, no pointer).
module sigma_mem_arb #(
  parameter int NUM_M     = 3,
  parameter int MAX_OUTST = 4,
  parameter int AW        = 32,
  parameter int DW        = 32
) (
  input  logic            clk_i,
  input  logic            arst_n_i,
  sigma_mem_arb_if.slave  bus,
  output logic            err_o
);
  localparam int IDW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int PW  = $clog2(MAX_OUTST);
  localparam int BW  = DW / 8;

  logic [IDW-1:0] r_fifo [MAX_OUTST];
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [PW:0]    r_count;
  logic           r_err;

  logic [NUM_M-1:0] w_elig;
  logic             w_full;
  logic             w_any;
  logic             w_accept;
  logic             w_push;
  logic             w_pop;
  logic             w_stray;
  logic [IDW-1:0]   w_gnt;

  // Registered count only: a pop in this cycle does not unblock a read until next cycle.
  assign w_full = (r_count == (PW+1)'(MAX_OUTST));
  assign w_elig = {NUM_M{arst_n_i}} & bus.m_req_i & (bus.m_we_i | {NUM_M{~w_full}});

`ifdef SIGMA_MEM_ARB_FIXED_PRIO_EN
  always_comb begin
    w_gnt = '0;
    w_any = 1'b0;
    for (int i = NUM_M - 1; i >= 0; i--) begin
      if (w_elig[IDW'(i)]) begin
        w_gnt = IDW'(i);
        w_any = 1'b1;
      end
    end
  end
`else
  logic [IDW-1:0] r_rr_ptr;
  logic [IDW-1:0] w_idx;

  always_comb begin
    w_gnt = '0;
    w_any = 1'b0;
    w_idx = '0;
    for (int i = 0; i < NUM_M; i++) begin
      w_idx = (int'(r_rr_ptr) + i >= NUM_M) ? IDW'(int'(r_rr_ptr) + i - NUM_M)
                                            : IDW'(int'(r_rr_ptr) + i);
      if (!w_any && w_elig[w_idx]) begin
        w_gnt = w_idx;
        w_any = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_rr_ptr <= '0;
    end else if (w_accept) begin
      r_rr_ptr <= (w_gnt == IDW'(NUM_M - 1)) ? '0 : w_gnt + 1'b1;
    end
  end
`endif

  always_comb begin
    bus.s_we_o    = 1'b0;
    bus.s_addr_o  = '0;
    bus.s_be_o    = '0;
    bus.s_wdata_o = '0;
    for (int k = 0; k < NUM_M; k++) begin
      if (w_any && (w_gnt == IDW'(k))) begin
        bus.s_we_o    = bus.m_we_i[k];
        bus.s_addr_o  = bus.m_addr_i[k*AW +: AW];
        bus.s_be_o    = bus.m_be_i[k*BW +: BW];
        bus.s_wdata_o = bus.m_wdata_i[k*DW +: DW];
      end
    end
  end

  assign bus.s_req_o   = w_any;
  assign w_accept      = w_any & bus.s_ack_i;
  assign bus.m_ack_o   = w_accept ? (NUM_M'(1) << w_gnt) : '0;
  assign w_push        = w_accept & ~bus.s_we_o;

  assign w_pop         = arst_n_i & bus.s_resp_i & (r_count != '0);
  assign w_stray       = bus.s_resp_i & (r_count == '0);
  assign bus.m_resp_o  = w_pop ? (NUM_M'(1) << r_fifo[r_rd_ptr]) : '0;
  assign bus.m_rdata_o = bus.s_rdata_i;
  assign err_o         = r_err;

  // ID storage needs no reset: entries are only read while count says they are valid.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= w_gnt;
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_err    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_stray) r_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sigma_mem_arb.sv
// Scoreboard bench for sigma_mem_arb: read IDs queued at issue, checked at response.
module tb_sigma_mem_arb;
  localparam int NUM_M = 3;
  localparam int MAX_OUTST = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic arst_n = 1'b0;
  logic err;

  sigma_mem_arb_if #(.NUM_M(NUM_M), .AW(AW), .DW(DW)) bus ();

  sigma_mem_arb #(.NUM_M(NUM_M), .MAX_OUTST(MAX_OUTST), .AW(AW), .DW(DW)) dut (
    .clk_i    (clk),
    .arst_n_i (arst_n),
    .bus      (bus),
    .err_o    (err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.m_req_i   = '0;
    bus.m_we_i    = '0;
    bus.m_addr_i  = '0;
    bus.m_be_i    = '0;
    bus.m_wdata_i = '0;
    bus.s_ack_i   = 1'b0;
    bus.s_resp_i  = 1'b0;
    bus.s_rdata_i = '0;
  endtask

  task automatic drive_m(input int k, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd);
    bus.m_req_i[k]              = 1'b1;
    bus.m_we_i[k]               = we;
    bus.m_addr_i[k*AW +: AW]    = addr;
    bus.m_be_i[k*4 +: 4]        = 4'hF;
    bus.m_wdata_i[k*DW +: DW]   = wd;
  endtask

  task automatic do_reset();
    idle();
    arst_n = 1'b0;
    step();
    step();
    arst_n = 1'b1;
    sb.delete();
  endtask

  // Lone read from master k; expected ID and the data the slave will return are queued.
  task automatic issue_read(input int k, input logic [31:0] addr, input logic [31:0] rdata);
    exp_t e;
    drive_m(k, 1'b0, addr, 32'h0);
    bus.s_ack_i = 1'b1;
    @(negedge clk);
    chk("rd_ack", 64'(bus.m_ack_o), 64'(1) << k);
    chk("rd_addr", 64'(bus.s_addr_o), 64'(addr));
    e.id = 2'(k);
    e.data = rdata;
    sb.push_back(e);
    step();
    bus.m_req_i[k] = 1'b0;
    bus.s_ack_i = 1'b0;
  endtask

  task automatic respond();
    exp_t e;
    e = sb.pop_front();
    bus.s_resp_i  = 1'b1;
    bus.s_rdata_i = e.data;
    @(negedge clk);
    chk("resp_route", 64'(bus.m_resp_o), 64'(1) << e.id);
    chk("resp_data", 64'(bus.m_rdata_o), 64'(e.data));
    step();
    bus.s_resp_i = 1'b0;
  endtask

  task automatic stray();
    bus.s_resp_i  = 1'b1;
    bus.s_rdata_i = $urandom;
    @(negedge clk);
    chk("stray_resp", 64'(bus.m_resp_o), 64'h0);
    step();
    bus.s_resp_i = 1'b0;
    @(negedge clk);
    chk("stray_err", 64'(err), 64'h1);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    logic [2:0] exp_ack;
    int exp_idx;

    // Reset held with activity on every input.
    idle();
    drive_m(0, 1'b0, 32'h100, 32'h0);
    bus.s_ack_i  = 1'b1;
    bus.s_resp_i = 1'b1;
    step();
    chk("rst_sreq", 64'(bus.s_req_o), 64'h0);
    chk("rst_ack", 64'(bus.m_ack_o), 64'h0);
    chk("rst_resp", 64'(bus.m_resp_o), 64'h0);
    chk("rst_err", 64'(err), 64'h0);
    do_reset();

    // Single read.
    drive_m(0, 1'b0, 32'h100, 32'h0);
    bus.s_ack_i = 1'b1;
    @(negedge clk);
    chk("t1_ack", 64'(bus.m_ack_o), 64'h1);
    chk("t1_sreq", 64'(bus.s_req_o), 64'h1);
    chk("t1_swe", 64'(bus.s_we_o), 64'h0);
    chk("t1_addr", 64'(bus.s_addr_o), 64'h100);
    e.id = 2'd0;
    e.data = 32'hDEADBEEF;
    sb.push_back(e);
    step();
    idle();
    step();
    respond();

    // Grant rotation with all three masters writing.
    do_reset();
    for (int k = 0; k < NUM_M; k++) drive_m(k, 1'b1, 32'h200 + 32'(k*4), 32'h1111_0000 + 32'(k));
    bus.s_ack_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
`ifdef SIGMA_MEM_ARB_FIXED_PRIO_EN
      exp_idx = 0;
`else
      exp_idx = i % NUM_M;
`endif
      exp_ack = 3'b001 << exp_idx;
      @(negedge clk);
      chk("rr_ack", 64'(bus.m_ack_o), 64'(exp_ack));
      chk("rr_wdata", 64'(bus.s_wdata_o), 64'(32'h1111_0000 + 32'(exp_idx)));
      chk("rr_we", 64'(bus.s_we_o), 64'h1);
      step();
    end
    idle();

    // FIFO full: reads from master 1 stall, a write from master 2 still passes.
    do_reset();
    drive_m(1, 1'b0, 32'h300, 32'h0);
    bus.s_ack_i = 1'b1;
    for (int i = 0; i < MAX_OUTST; i++) begin
      @(negedge clk);
      chk("full_fill_ack", 64'(bus.m_ack_o), 64'h2);
      e.id = 2'd1;
      e.data = 32'hF000_0000 + 32'(i);
      sb.push_back(e);
      step();
    end
    drive_m(2, 1'b1, 32'h400, 32'hCAFE);
    @(negedge clk);
    chk("full_wr_ack", 64'(bus.m_ack_o), 64'h4);
    chk("full_wr_we", 64'(bus.s_we_o), 64'h1);
    chk("full_wr_data", 64'(bus.s_wdata_o), 64'hCAFE);
    step();
    bus.m_req_i[2] = 1'b0;
    @(negedge clk);
    chk("full_block_req", 64'(bus.s_req_o), 64'h0);
    chk("full_block_ack", 64'(bus.m_ack_o), 64'h0);
    step();
    e = sb.pop_front();
    bus.s_resp_i  = 1'b1;
    bus.s_rdata_i = e.data;
    @(negedge clk);
    chk("full_pop_resp", 64'(bus.m_resp_o), 64'h2);
    chk("full_pop_data", 64'(bus.m_rdata_o), 64'(e.data));
    chk("full_pop_sreq", 64'(bus.s_req_o), 64'h0);
    step();
    bus.s_resp_i = 1'b0;
    @(negedge clk);
    chk("full_resume_ack", 64'(bus.m_ack_o), 64'h2);
    e.id = 2'd1;
    e.data = 32'hF000_0004;
    sb.push_back(e);
    step();
    idle();
    for (int i = 0; i < MAX_OUTST; i++) respond();

    // Response routing in acceptance order 2, 0, 1.
    do_reset();
    issue_read(2, 32'h700, 32'hAAAA_0002);
    issue_read(0, 32'h704, 32'hAAAA_0000);
    issue_read(1, 32'h708, 32'hAAAA_0001);
    respond();
    respond();
    respond();

    // Stray response sets a sticky error that only reset clears.
    stray();
    step();
    step();
    @(negedge clk);
    chk("err_sticky", 64'(err), 64'h1);
    do_reset();
    @(negedge clk);
    chk("err_cleared", 64'(err), 64'h0);

    // Reset in the middle of outstanding reads.
    issue_read(0, 32'h500, 32'h5000_0000);
    issue_read(0, 32'h504, 32'h5000_0004);
    drive_m(0, 1'b0, 32'h508, 32'h0);
    bus.s_ack_i  = 1'b1;
    bus.s_resp_i = 1'b1;
    #2;
    arst_n = 1'b0;
    #1;
    chk("mid_rst_sreq", 64'(bus.s_req_o), 64'h0);
    chk("mid_rst_ack", 64'(bus.m_ack_o), 64'h0);
    chk("mid_rst_resp", 64'(bus.m_resp_o), 64'h0);
    sb.delete();
    idle();
    step();
    arst_n = 1'b1;
    stray();
    issue_read(0, 32'h600, 32'h6000_0000);
    step();
    respond();
    chk("sb_empty", 64'(sb.size()), 64'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sigma_mem_arb.md
Name: sigma_mem_arb

Overview:
- Round-robin arbiter that shares one sigma memory/peripheral bus slave port between N bus masters, e.g. CPU instruction port, CPU data port, UART debug loader.
- Multiplexes request channels onto the single slave port.
- Tracks outstanding reads in an ID FIFO so each read response returns to its issuing master in order.
- Sits between the masters and the sigma RAM/IO interconnect, on the SoC clock.

Parameters:
- NUM_M, 3, number of masters (2..4).
- MAX_OUTST, 4, maximum outstanding reads (ID FIFO depth, power of 2, ≥2).
- AW, 32, address width.
- DW, 32, data width.

Ports:
- clk_i  in  1  SoC clock.
- arst_n_i  in  1  asynchronous active-low reset.
- m_req_i  in  NUM_M  per-master request.
- m_we_i  in  NUM_M  per-master write enable (1 = write).
- m_addr_i  in  NUM_M*AW  per-master address, master k at [k*AW +: AW].
- m_be_i  in  NUM_M*DW/8  per-master byte enables.
- m_wdata_i  in  NUM_M*DW  per-master write data.
- m_ack_o  out  NUM_M  request accepted, one-hot.
- m_resp_o  out  NUM_M  read data valid, one-hot.
- m_rdata_o  out  DW  read data, shared by all masters.
- s_req_o  out  1  slave request.
- s_we_o  out  1  slave write enable.
- s_addr_o  out  AW  slave address.
- s_be_o  out  DW/8  slave byte enables.
- s_wdata_o  out  DW  slave write data.
- s_ack_i  in  1  slave accepted request.
- s_resp_i  in  1  slave read data valid.
- s_rdata_i  in  DW  slave read data.
- err_o  out  1  sticky error: response arrived with ID FIFO empty.

Behaviour:
- Reset (async assert, sync-to-clock deassert is the caller's concern):
  - rr_ptr = 0; ID FIFO empty (wr_ptr = rd_ptr = 0, count = 0); err_o = 0.
  - All m_ack_o, m_resp_o, s_req_o are 0 while reset is held.
- Eligibility: master k is eligible when m_req_i[k] = 1, and additionally FIFO not full if m_we_i[k] = 0.
  - Writes are never blocked by a full FIFO.
- Grant (combinational, zero latency):
  - Search eligible masters starting at rr_ptr, ascending with wrap, NUM_M-1 → 0.
  - The first hit is the grant g.
- Slave outputs:
  - s_req_o = 1 if any master is eligible.
  - s_we_o, s_addr_o, s_be_o, s_wdata_o = master g's fields.
  - When s_req_o = 0, the data outputs drive 0.
- Ack: m_ack_o[g] = s_req_o & s_ack_i; all other bits 0.
  - A transfer is "accepted" in the cycle where s_req_o & s_ack_i.
  - Masters hold request fields stable until acked (sigma bus rule).
- On acceptance, at the clock edge:
  - rr_ptr ← (g+1) mod NUM_M.
  - If read: push g into the FIFO at wr_ptr, wr_ptr++ (wraps mod MAX_OUTST), count++.
- rr_ptr is unchanged when there is no acceptance. A stalled grant (s_ack_i = 0) may change if requests change.
- Response:
  - When s_resp_i = 1 and count > 0: m_resp_o[fifo[rd_ptr]] = 1, m_rdata_o = s_rdata_i (combinational pass-through); at the edge rd_ptr++, count--.
  - m_rdata_o = s_rdata_i at all times, qualified only by m_resp_o.
- Simultaneous push and pop: both pointers advance, count unchanged.
  - Full-FIFO eligibility uses registered count, so a read is blocked in a cycle where count = MAX_OUTST even if a pop occurs that same cycle.
- s_resp_i with count = 0: no m_resp_o asserted, FIFO state unchanged, err_o ← 1. err_o clears only on reset.
- Reset mid-operation: outstanding IDs are discarded. Responses arriving after reset set err_o.
- Response ordering: responses are returned strictly in acceptance order. The slave must respond in order.

Optional Feature:
- Macro SIGMA_MEM_ARB_FIXED_PRIO_EN.
- Defined: grant is fixed priority, lowest eligible index wins; rr_ptr is removed (no state).
- Undefined: round-robin as above.
- FIFO, error and response behaviour are identical in both builds.

Test Plan:
- Single read: m_req_i = 001, we = 0, addr = 0x100, s_ack_i = 1 → m_ack_o = 001 same cycle, s_addr_o = 0x100. Two cycles later s_resp_i = 1, s_rdata_i = 0xDEADBEEF → m_resp_o = 001, m_rdata_o = 0xDEADBEEF.
- Round-robin: m_req_i held at 111, s_ack_i = 1, responses immediate → ack sequence 001, 010, 100, 001. With SIGMA_MEM_ARB_FIXED_PRIO_EN → 001 every cycle.
- FIFO full: 4 reads from master 1 acked with s_resp_i = 0, then a 5th read → s_req_o = 0. A concurrent write from master 2 is acked. After one s_resp_i (m_resp_o = 010), the read is accepted next cycle.
- Response routing: reads accepted from masters 2, 0, 1 in that order, then three s_resp_i pulses → m_resp_o = 100, 001, 010 in sequence.
- Stray response: s_resp_i = 1 with FIFO empty → m_resp_o = 000, err_o = 1 from next cycle, sticky until arst_n_i low.
- Reset mid-op: 2 reads outstanding, pulse arst_n_i low → all outputs 0 immediately. A subsequent s_resp_i sets err_o; a new read from master 0 routes correctly.
